// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer: owns the cipher state, steps an external round datapath and key store.
// Optional build macro AES_ABORT_EN adds an abort_i port that returns ROUND/DONE to IDLE.
module aes_round_ctrl #(
    parameter int unsigned NR       = 10,
    parameter int unsigned RK_IDX_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [127:0]        in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [127:0]        out_data_o,
    output logic [RK_IDX_W-1:0] rk_idx_o,
    input  logic [127:0]        rk_data_i,
    output logic [127:0]        dp_state_o,
    output logic                dp_last_o,
    input  logic [127:0]        dp_result_i
`ifdef AES_ABORT_EN
    ,
    input  logic                abort_i
`endif
);

    localparam int unsigned BLK_W = 128;
    localparam logic [RK_IDX_W-1:0] LAST_RND = RK_IDX_W'(NR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_e;

    fsm_e                fsm_q, fsm_d;
    logic [RK_IDX_W-1:0] cnt_q, cnt_d;
    logic [BLK_W-1:0]    state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                dp_last_q, dp_last_d;
    logic                abort_c;

`ifdef AES_ABORT_EN
    assign abort_c = abort_i;
`else
    assign abort_c = 1'b0;
`endif

    // Next state; handshake flags are derived from the next state so every output is a flop.
    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        dp_last_d   = 1'b0;

        case (fsm_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    state_d = in_data_i ^ rk_data_i;
                    cnt_d   = RK_IDX_W'(1);
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = dp_result_i ^ rk_data_i;
                if (cnt_q == LAST_RND) begin
                    cnt_d = '0;
                    fsm_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + RK_IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
                cnt_d = '0;
            end
        endcase

        // Abort only matters once a block is in flight; accepting in IDLE takes precedence.
        if (abort_c && (fsm_q != S_IDLE)) begin
            fsm_d   = S_IDLE;
            cnt_d   = '0;
            state_d = '0;
        end

        in_ready_d  = (fsm_d == S_IDLE);
        out_valid_d = (fsm_d == S_DONE);
        dp_last_d   = (fsm_d == S_ROUND) && (cnt_d == LAST_RND);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q       <= S_IDLE;
            cnt_q       <= '0;
            state_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dp_last_q   <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            dp_last_q   <= dp_last_d;
        end
    end

    // Round counter is held at zero outside ROUND, so it doubles as the key index.
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = state_q;
    assign dp_state_o  = state_q;
    assign dp_last_o   = dp_last_q;
    assign rk_idx_o    = cnt_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: golden AES-128 round datapath/key schedule plus a ciphertext scoreboard.
// Define AES_ABORT_EN for both bench and RTL to exercise the abort port.
module tb_aes_round_ctrl;

    localparam int unsigned NR       = 10;
    localparam int unsigned RK_IDX_W = 4;
    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [127:0]        in_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [127:0]        out_data;
    logic [RK_IDX_W-1:0] rk_idx;
    logic [127:0]        rk_data;
    logic [127:0]        dp_state;
    logic                dp_last;
    logic [127:0]        dp_result;
    logic                abort = 1'b0;

    logic [127:0] rk_tab [16];
    logic [127:0] exp_q [$];
    int           acc_q [$];
    int           cyc = 0;
    int           trk = 0;
    logic         prev_ov = 1'b0;
    int           n_pop = 0;
    int           n_chk = 0;
    int           n_pass = 0;

    aes_round_ctrl #(.NR(NR), .RK_IDX_W(RK_IDX_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .rk_idx_o    (rk_idx),
        .rk_data_i   (rk_data),
        .dp_state_o  (dp_state),
        .dp_last_o   (dp_last),
        .dp_result_i (dp_result)
`ifdef AES_ABORT_EN
        ,
        .abort_i     (abort)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        else n_pass++;
    endtask

    // ---------------- golden AES model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Multiplicative inverse as x^254, then the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r+4*c] = b[r + 4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                logic [7:0] a0, a1, a2, a3;
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk_tab[0];
        for (int r = 1; r <= int'(NR); r++) s = round_fn(s, r == int'(NR)) ^ rk_tab[r];
        return s;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 16; r++) rk_tab[r] = '0;
        for (int r = 0; r <= int'(NR); r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Combinational round datapath and key store seen by the DUT.
    always_comb dp_result = round_fn(dp_state, dp_last);
    assign rk_data = rk_tab[rk_idx];

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (trk != 0) begin
            check("rk_idx_seq", 128'(rk_idx), 128'(trk));
            check("dp_last_seq", 128'(dp_last), 128'(trk == int'(NR)));
        end
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            trk     = 0;
            prev_ov = 1'b0;
        end else if (in_valid && in_ready) begin
            check("rk_idx_accept", 128'(rk_idx), 128'(0));
            exp_q.push_back(aes_enc(in_data));
            acc_q.push_back(cyc);
            trk     = 1;
            prev_ov = out_valid;
        end else if (abort && !in_ready) begin
            exp_q.delete();
            acc_q.delete();
            trk     = 0;
            prev_ov = 1'b0;
        end else begin
            if (trk == int'(NR)) trk = 0;
            else if (trk != 0) trk++;
            if (out_valid && !prev_ov) begin
                if (acc_q.size() > 0) check("latency", 128'(cyc - acc_q.pop_front()), 128'(NR + 1));
                else check("spurious_valid", 128'(out_valid), 128'(0));
            end
            if (out_valid && out_ready) begin
                n_pop++;
                if (exp_q.size() > 0) check("ciphertext", out_data, exp_q.pop_front());
                else check("spurious_out", 128'(out_valid), 128'(0));
            end
            prev_ov = out_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_in_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 128'(in_ready), 128'(1));
    endtask

    task automatic wait_rk(input int idx);
        int n;
        n = 0;
        @(negedge clk);
        while (int'(rk_idx) != idx && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (int'(rk_idx) != idx) check("rk_wait_timeout", 128'(rk_idx), 128'(idx));
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("out_valid_timeout", 128'(out_valid), 128'(1));
    endtask

    task automatic send(input logic [127:0] pt);
        @(posedge clk); #1;
        in_data  = pt;
        in_valid = 1'b1;
        wait_in_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] pts [4];
        int           acc [4];
        int           n;
        int           exp_pops;

        expand_key(KEY);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_rk_idx", 128'(rk_idx), 128'(0));
        check("rst_dp_last", 128'(dp_last), 128'(0));
        check("rst_state", out_data, 128'(0));

        // FIPS-197 vector with 20 cycles of backpressure
        send(PT1);
        wait_out();
        check("fips_ct", out_data, CT1);
        for (int i = 0; i < 20; i++) begin
            check("hold_data", out_data, CT1);
            check("hold_in_ready", 128'(in_ready), 128'(0));
            check("hold_valid", 128'(out_valid), 128'(1));
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("drain_in_ready", 128'(in_ready), 128'(1));
        check("drain_valid", 128'(out_valid), 128'(0));

        // in_valid pulse during round 5 is ignored
        send(PT1);
        wait_rk(4);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 128'h00112233445566778899aabbccddeeff;
        @(negedge clk);
        check("busy_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1 in_valid = 1'b0;
        wait_out();
        check("ignore_ct", out_data, CT1);

        // Synchronous reset in round 7 discards the block
        send(PT1);
        wait_rk(6);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", 128'(in_ready), 128'(1));
        check("mid_rst_valid", 128'(out_valid), 128'(0));
        check("mid_rst_state", dp_state, 128'(0));
        send(PT1);
        wait_out();
        check("post_rst_ct", out_data, CT1);

        // Four back-to-back blocks with out_ready tied high
        pts[0] = PT1;
        for (int k = 1; k < 4; k++) pts[k] = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            in_data  = pts[k];
            in_valid = 1'b1;
            wait_in_ready();
            acc[k] = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int k = 1; k < 4; k++) check("b2b_gap", 128'(acc[k] - acc[k-1]), 128'(NR + 2));
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_drained", 128'(exp_q.size()), 128'(0));
        exp_pops = 7;

`ifdef AES_ABORT_EN
        // Abort in round 3, then abort coinciding with a new block in IDLE
        send(PT1);
        wait_rk(2);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 128'(in_ready), 128'(1));
        check("abort_valid", 128'(out_valid), 128'(0));
        check("abort_state", out_data, 128'(0));
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("abort_no_out", 128'(out_valid), 128'(0));
        end
        @(posedge clk); #1;
        in_data  = PT1;
        in_valid = 1'b1;
        abort    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        wait_out();
        check("abort_idle_ct", out_data, CT1);
        exp_pops = 8;
`endif

        repeat (3) @(negedge clk);
        check("pop_count", 128'(n_pop), 128'(exp_pops));
        check("sb_empty", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
